// File: rtl/sasa_tile_engine.sv
// Tile engine: walks a score map in BLKxBLK tiles, finds each tile max and streams max-minus-element.
// Optional build macro SASA_CLAMP_EN adds clamp_val and saturates out_data at it.
module sasa_tile_engine #(
    parameter int DW     = 8,
    parameter int BLK    = 4,
    parameter int MAP_W  = 16,
    parameter int MAP_H  = 16,
    parameter int STRIDE = 4,
    parameter int AW     = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          data_req,
    output logic [AW-1:0] data_addr_x,
    output logic [AW-1:0] data_addr_y,
    input  logic [DW-1:0] data_in,
`ifdef SASA_CLAMP_EN
    input  logic [DW-1:0] clamp_val,
`endif
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic [DW-1:0] tile_max,
    output logic          tile_done,
    output logic          busy,
    output logic          finish
);

    localparam int N  = BLK * BLK;
    localparam int CW = $clog2(N + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [AW-1:0] PX_LAST  = AW'(MAP_W - BLK);
    localparam logic [AW-1:0] PY_LAST  = AW'(MAP_H - BLK);
    localparam logic [AW-1:0] STEP     = AW'(STRIDE);
    localparam logic [AW-1:0] OFF_LAST = AW'(BLK - 1);
    localparam logic [CW-1:0] CNT_N    = CW'(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_PEN  = CW'(N - 2);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FINDMAX, S_SUB, S_NEXT, S_DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] px_q, py_q, ox_q, oy_q;
    logic [DW-1:0] tile_buf_q [N];
    logic [DW-1:0] acc_q, tile_max_q;
    logic          data_req_q, out_valid_q, out_last_q, tile_done_q, busy_q, finish_q;
    logic [AW-1:0] addr_x_q, addr_y_q;

    logic [CW-1:0] cnt_dec;
    logic [IW-1:0] idx, widx;
    logic [AW-1:0] ox_d, oy_d, px_d, py_d;
    logic          last_tile, accept;
    logic [DW-1:0] scan, fm_max, diff, out_val;

    assign cnt_dec   = cnt_q - CW'(1);
    assign idx       = cnt_q[IW-1:0];
    assign widx      = cnt_dec[IW-1:0];
    assign ox_d      = (ox_q == OFF_LAST) ? '0 : ox_q + AW'(1);
    assign oy_d      = (ox_q == OFF_LAST) ? oy_q + AW'(1) : oy_q;
    assign px_d      = (px_q < PX_LAST) ? px_q + STEP : '0;
    assign py_d      = (px_q < PX_LAST) ? py_q : py_q + STEP;
    assign last_tile = (px_q == PX_LAST) && (py_q == PY_LAST);
    assign accept    = out_valid_q && out_ready;

    // Strict compare keeps the earlier element on ties.
    assign scan   = tile_buf_q[idx];
    assign fm_max = (cnt_q == '0 || scan > acc_q) ? scan : acc_q;
    assign diff   = tile_max_q - scan;
`ifdef SASA_CLAMP_EN
    assign out_val = (diff > clamp_val) ? clamp_val : diff;
`else
    assign out_val = diff;
`endif

    assign out_data    = out_valid_q ? out_val : '0;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign tile_max    = tile_max_q;
    assign tile_done   = tile_done_q;
    assign busy        = busy_q;
    assign finish      = finish_q;
    assign data_req    = data_req_q;
    assign data_addr_x = addr_x_q;
    assign data_addr_y = addr_y_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            px_q        <= '0;
            py_q        <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            acc_q       <= '0;
            tile_max_q  <= '0;
            data_req_q  <= 1'b0;
            addr_x_q    <= '0;
            addr_y_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            tile_done_q <= 1'b0;
            busy_q      <= 1'b0;
            finish_q    <= 1'b0;
            for (int i = 0; i < N; i++) tile_buf_q[i] <= '0;
        end else begin
            tile_done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q    <= S_LOAD;
                        px_q       <= '0;
                        py_q       <= '0;
                        ox_q       <= '0;
                        oy_q       <= '0;
                        cnt_q      <= '0;
                        data_req_q <= 1'b1;
                        addr_x_q   <= '0;
                        addr_y_q   <= '0;
                        busy_q     <= 1'b1;
                        finish_q   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    // Read data trails its request by one cycle, so write one slot behind.
                    if (cnt_q != '0) tile_buf_q[widx] <= data_in;
                    if (cnt_q == CNT_N) begin
                        state_q <= S_FINDMAX;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CNT_LAST) begin
                            data_req_q <= 1'b0;
                        end else begin
                            ox_q     <= ox_d;
                            oy_q     <= oy_d;
                            addr_x_q <= px_q + ox_d;
                            addr_y_q <= py_q + oy_d;
                        end
                    end
                end
                S_FINDMAX: begin
                    acc_q <= fm_max;
                    if (cnt_q == CNT_LAST) begin
                        tile_max_q  <= fm_max;
                        state_q     <= S_SUB;
                        cnt_q       <= '0;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (N == 1);
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_SUB: begin
                    if (accept) begin
                        if (cnt_q == CNT_LAST) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            tile_done_q <= 1'b1;
                            state_q     <= S_NEXT;
                        end else begin
                            cnt_q      <= cnt_q + CW'(1);
                            out_last_q <= (cnt_q == CNT_PEN);
                        end
                    end
                end
                S_NEXT: begin
                    if (last_tile) begin
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        finish_q <= 1'b1;
                    end else begin
                        state_q    <= S_LOAD;
                        px_q       <= px_d;
                        py_q       <= py_d;
                        ox_q       <= '0;
                        oy_q       <= '0;
                        cnt_q      <= '0;
                        data_req_q <= 1'b1;
                        addr_x_q   <= px_d;
                        addr_y_q   <= py_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sasa_tile_engine.sv
// Directed bench for sasa_tile_engine on an 8x8 map with 4x4 tiles, stride 4.
module tb_sasa_tile_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] data_in;
    logic       data_req, out_valid, out_last, tile_done, busy, finish;
    logic [3:0] data_addr_x, data_addr_y;
    logic [7:0] out_data, tile_max;
`ifdef SASA_CLAMP_EN
    logic [7:0] clamp_val = 8'hFF;
`endif

    int checks = 0;
    int errors = 0;
    int mode = 0;

    always #5 clk = ~clk;

    sasa_tile_engine #(.DW(8), .BLK(4), .MAP_W(8), .MAP_H(8), .STRIDE(4), .AW(4)) dut (
        .clk(clk), .reset(reset), .start(start),
        .data_req(data_req), .data_addr_x(data_addr_x), .data_addr_y(data_addr_y),
        .data_in(data_in),
`ifdef SASA_CLAMP_EN
        .clamp_val(clamp_val),
`endif
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .tile_max(tile_max), .tile_done(tile_done),
        .busy(busy), .finish(finish)
    );

    function automatic logic [7:0] memv(input int m, input int x, input int y);
        if (m == 0) return 8'(16 * y + x);
        if (x < 4) return 8'h7F;
        if (x == 5 && y == 2) return 8'hFF;
        return 8'h10;
    endfunction

    function automatic logic [7:0] elem(input int m, input int b);
        int t = b / 16;
        int j = b % 16;
        return memv(m, (t % 2) * 4 + j % 4, (t / 2) * 4 + j / 4);
    endfunction

    function automatic logic [7:0] tmax(input int m, input int t);
        logic [7:0] mx = 8'h00;
        for (int j = 0; j < 16; j++)
            if (elem(m, t * 16 + j) > mx) mx = elem(m, t * 16 + j);
        return mx;
    endfunction

    function automatic logic [7:0] exp_out(input int m, input int b);
        return tmax(m, b / 16) - elem(m, b);
    endfunction

    always @(posedge clk) data_in <= data_req ? memv(mode, int'(data_addr_x), int'(data_addr_y)) : 8'h00;

    // Monitor: captures accepted beats, pivots, tile_done pulses and stall stability.
    logic [7:0] bdata [256];
    logic       blast [256];
    logic [7:0] bmax  [256];
    logic [3:0] ppx [16];
    logic [3:0] ppy [16];
    int nb = 0, ntd = 0, np = 0, nbusy = 0, nviol = 0, nstall = 0;
    bit mon_clr = 0, req_prev = 0, stall_prev = 0;
    logic [7:0] data_prev = 8'h00;

    always @(negedge clk) begin
        if (mon_clr) begin
            nb = 0; ntd = 0; np = 0; nbusy = 0; nviol = 0; nstall = 0; stall_prev = 0;
        end else begin
            if (out_valid && out_ready && nb < 256) begin
                bdata[nb] = out_data; blast[nb] = out_last; bmax[nb] = tile_max; nb++;
            end
            if (tile_done) ntd++;
            if (data_req && !req_prev && np < 16) begin
                ppx[np] = data_addr_x; ppy[np] = data_addr_y; np++;
            end
            if (busy) nbusy++;
            if (stall_prev && (out_valid !== 1'b1 || out_data !== data_prev)) nviol++;
            stall_prev = out_valid && !out_ready;
            if (stall_prev) nstall++;
            data_prev = out_data;
        end
        req_prev = data_req;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        tick(); start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic clear_mon();
        tick(); mon_clr = 1'b1; tick(); mon_clr = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit stall);
        int c = 0;
        while (finish !== 1'b1 && c < budget) begin
            tick();
            if (stall) out_ready = (c % 4 == 0) || (c % 4 == 3);
            c++;
        end
        out_ready = 1'b1;
        checks++;
        if (finish !== 1'b1) begin
            errors++; $display("FAIL wait_done: finish=%b after %0d cycles, required 1", finish, c);
        end
        tick();
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++;
        if ({busy, finish, out_valid, out_last, data_req, tile_done} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b required 000000",
                               {busy, finish, out_valid, out_last, data_req, tile_done});
        end
        checks++;
        if ({out_data, tile_max, data_addr_x, data_addr_y} !== 24'h0) begin
            errors++; $display("FAIL reset_data: got %h required 000000",
                               {out_data, tile_max, data_addr_x, data_addr_y});
        end
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_map_pass();
        logic [7:0] hand [6] = '{8'd51, 8'd50, 8'd49, 8'd48, 8'd35, 8'd0};
        int hidx [6] = '{0, 1, 2, 3, 4, 15};
        mode = 0; clear_mon(); pulse_start(); wait_done(1000, 0);
        checks++; if (ntd !== 4) begin errors++; $display("FAIL map_tile_done: got %0d required 4", ntd); end
        checks++; if (np !== 4) begin errors++; $display("FAIL map_pivots: got %0d required 4", np); end
        for (int t = 0; t < 4; t++) begin
            checks++;
            if (ppx[t] !== 4'((t % 2) * 4) || ppy[t] !== 4'((t / 2) * 4)) begin
                errors++; $display("FAIL map_pivot%0d: got (%0d,%0d) required (%0d,%0d)",
                                   t, ppx[t], ppy[t], (t % 2) * 4, (t / 2) * 4);
            end
        end
        checks++; if (nb !== 64) begin errors++; $display("FAIL map_beats: got %0d required 64", nb); end
        checks++; if (nbusy !== 200) begin errors++; $display("FAIL map_latency: got %0d required 200", nbusy); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL map_busy: got %b required 0", busy); end
        checks++; if (bmax[0] !== 8'd51) begin errors++; $display("FAIL map_tmax0: got %0d required 51", bmax[0]); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (bdata[hidx[i]] !== hand[i]) begin
                errors++; $display("FAIL map_hand%0d: got %0d required %0d", hidx[i], bdata[hidx[i]], hand[i]);
            end
        end
        for (int b = 0; b < 64; b++) begin
            checks++;
            if (bdata[b] !== exp_out(0, b) || blast[b] !== (b % 16 == 15) || bmax[b] !== tmax(0, b / 16)) begin
                errors++; $display("FAIL map_beat%0d: got d=%0d l=%b m=%0d required d=%0d l=%b m=%0d", b,
                                   bdata[b], blast[b], bmax[b], exp_out(0, b), (b % 16 == 15), tmax(0, b / 16));
            end
        end
        $display("test_map_pass done: %0d beats, %0d tiles", nb, ntd);
    endtask

    task automatic test_equal_and_max();
        mode = 1; clear_mon(); pulse_start(); wait_done(1000, 0);
        checks++; if (bmax[0] !== 8'h7F) begin errors++; $display("FAIL eq_tmax: got %h required 7f", bmax[0]); end
        checks++; if (bmax[16] !== 8'hFF) begin errors++; $display("FAIL ff_tmax: got %h required ff", bmax[16]); end
        checks++; if (bdata[25] !== 8'h00) begin errors++; $display("FAIL ff_elem: got %h required 00", bdata[25]); end
        checks++; if (bdata[16] !== 8'hEF) begin errors++; $display("FAIL ff_other: got %h required ef", bdata[16]); end
        for (int b = 0; b < 16; b++) begin
            checks++;
            if (bdata[b] !== 8'h00) begin errors++; $display("FAIL eq_beat%0d: got %h required 00", b, bdata[b]); end
        end
        for (int b = 16; b < 64; b++) begin
            checks++;
            if (bdata[b] !== exp_out(1, b)) begin
                errors++; $display("FAIL eqmax_beat%0d: got %h required %h", b, bdata[b], exp_out(1, b));
            end
        end
        mode = 0;
        $display("test_equal_and_max done: %0d beats", nb);
    endtask

    task automatic test_stall();
        mode = 0; clear_mon(); pulse_start(); wait_done(2000, 1);
        checks++; if (nb !== 64) begin errors++; $display("FAIL stall_beats: got %0d required 64", nb); end
        checks++; if (nviol !== 0) begin errors++; $display("FAIL stall_stable: got %0d violations required 0", nviol); end
        checks++; if (nstall == 0) begin errors++; $display("FAIL stall_seen: got 0 stalls required >0"); end
        for (int b = 0; b < 64; b++) begin
            checks++;
            if (bdata[b] !== exp_out(0, b) || blast[b] !== (b % 16 == 15)) begin
                errors++; $display("FAIL stall_beat%0d: got d=%0d l=%b required d=%0d l=%b",
                                   b, bdata[b], blast[b], exp_out(0, b), (b % 16 == 15));
            end
        end
        $display("test_stall done: %0d beats, %0d stall cycles", nb, nstall);
    endtask

    task automatic test_reset_mid();
        int c = 0;
        mode = 0; clear_mon(); pulse_start();
        while (!(ntd == 1 && out_valid === 1'b1) && c < 500) begin tick(); c++; end
        checks++;
        if (!(ntd == 1 && out_valid === 1'b1)) begin errors++; $display("FAIL rmid_reach: got ntd=%0d required SUB of tile 1", ntd); end
        reset = 1'b1; #2;
        checks++;
        if ({busy, finish, out_valid, out_last, data_req, tile_done} !== 6'b0 ||
            {out_data, tile_max, data_addr_x, data_addr_y} !== 24'h0) begin
            errors++; $display("FAIL rmid_outputs: got flags=%b data=%h required 0",
                               {busy, finish, out_valid, out_last, data_req, tile_done},
                               {out_data, tile_max, data_addr_x, data_addr_y});
        end
        tick(); tick(); reset = 1'b0; tick();
        checks++; if (ntd !== 1) begin errors++; $display("FAIL rmid_no_done: got %0d required 1", ntd); end
        clear_mon(); pulse_start(); wait_done(1000, 0);
        checks++;
        if (ppx[0] !== 4'd0 || ppy[0] !== 4'd0 || ntd !== 4 || nb !== 64 || bdata[0] !== 8'd51) begin
            errors++; $display("FAIL rmid_restart: got pivot=(%0d,%0d) tiles=%0d beats=%0d first=%0d required (0,0) 4 64 51",
                               ppx[0], ppy[0], ntd, nb, bdata[0]);
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_start_ignored();
        mode = 0; clear_mon(); pulse_start();
        tick(); tick(); tick(); start = 1'b1; tick(); start = 1'b0;
        wait_done(1000, 0);
        checks++;
        if (ntd !== 4 || nb !== 64 || nbusy !== 200) begin
            errors++; $display("FAIL start_in_load: got tiles=%0d beats=%0d busy=%0d required 4 64 200", ntd, nb, nbusy);
        end
        checks++; if (finish !== 1'b1) begin errors++; $display("FAIL done_finish: got %b required 1", finish); end
        clear_mon(); start = 1'b1; tick();
        checks++;
        if (finish !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL done_restart: got finish=%b busy=%b required 0 1", finish, busy);
        end
        start = 1'b0;
        wait_done(1000, 0);
        checks++; if (ntd !== 4 || nb !== 64) begin errors++; $display("FAIL rerun_counts: got %0d %0d required 4 64", ntd, nb); end
        for (int b = 0; b < 64; b++) begin
            checks++;
            if (bdata[b] !== exp_out(0, b)) begin
                errors++; $display("FAIL rerun_beat%0d: got %0d required %0d", b, bdata[b], exp_out(0, b));
            end
        end
        $display("test_start_ignored done");
    endtask

`ifdef SASA_CLAMP_EN
    task automatic test_clamp();
        logic [7:0] e;
        clamp_val = 8'd10; mode = 0; clear_mon(); pulse_start(); wait_done(1000, 0);
        checks++; if (nb !== 64) begin errors++; $display("FAIL clamp_beats: got %0d required 64", nb); end
        for (int b = 0; b < 10; b++) begin
            checks++;
            if (bdata[b] !== 8'd10) begin errors++; $display("FAIL clamp_sat%0d: got %0d required 10", b, bdata[b]); end
        end
        for (int b = 0; b < 64; b++) begin
            e = (exp_out(0, b) > 8'd10) ? 8'd10 : exp_out(0, b);
            checks++;
            if (bdata[b] !== e) begin errors++; $display("FAIL clamp_beat%0d: got %0d required %0d", b, bdata[b], e); end
        end
        clamp_val = 8'hFF;
        $display("test_clamp done");
    endtask
`endif

    initial begin
        test_reset();
        test_map_pass();
        test_equal_and_max();
        test_stall();
        test_reset_mid();
        test_start_ignored();
`ifdef SASA_CLAMP_EN
        test_clamp();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sasa_tile_engine.md
Name: sasa_tile_engine

Overview:
Parametrised successor to the single-pass SASA controller. Walks a MAP_W x MAP_H score map in BLK x BLK tiles spaced by STRIDE. For each tile it:
- loads the tile into a local buffer;
- finds the tile maximum;
- streams max-minus-element values out over a valid/ready handshake.

Sits between the QK score memory and the downstream softmax/exp stage.

Parameters:
DW, 8, score data width (unsigned)
BLK, 4, tile edge; tile holds N = BLK*BLK elements
MAP_W, 16, score map width
MAP_H, 16, score map height
STRIDE, 4, pivot step in x and y; legal only if (MAP_W-BLK)%STRIDE==0 and (MAP_H-BLK)%STRIDE==0
AW, 4, address width, >= clog2(max(MAP_W,MAP_H))

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
start  in  1  begin a full map pass; sampled in IDLE/DONE only
data_req  out  1  memory read strobe
data_addr_x  out  AW  column = pivot_x + k%BLK
data_addr_y  out  AW  row = pivot_y + k/BLK
data_in  in  DW  read data, valid exactly 1 cycle after data_req
out_data  out  DW  max - element
out_valid  out  1  out_data valid
out_ready  in  1  downstream accept
out_last  out  1  high with last element of a tile
tile_max  out  DW  max of current tile, valid from SUB entry until next LOAD
tile_done  out  1  1-cycle pulse per completed tile
busy  out  1  high in any state except IDLE/DONE
finish  out  1  high in DONE

Behaviour:
- Reset: state=IDLE, pivots=0, counters=0, buffer=0. All outputs 0.
- States and transitions:
  - IDLE: start -> LOAD.
  - LOAD -> FINDMAX -> SUB -> NEXT.
  - NEXT -> LOAD, or DONE after the final tile.
  - DONE: start -> LOAD with pivot_x = pivot_y = 0.
- start is ignored in LOAD/FINDMAX/SUB/NEXT.
- LOAD: N+1 cycles.
  - Cycles 0..N-1: data_req=1, k=cycle index, addresses as above.
  - data_in is written to buf[k] one cycle after its request. The cycle after the last request only captures.
  - data_req=0 and addresses hold their last value outside LOAD.
- FINDMAX: N cycles, scans buf[0..N-1].
  - Unsigned compare.
  - Ties keep the earlier value; the result is identical either way.
  - tile_max is registered on exit.
- SUB: index j from 0.
  - out_valid=1; out_data = tile_max - buf[j]. The result is always >= 0, so no wrap.
  - j advances only on out_valid & out_ready.
  - out_data/out_valid hold stable while out_ready=0.
  - out_last = (j==N-1).
  - The handshake on j==N-1 moves the FSM to NEXT. There is no bubble between elements when out_ready stays high.
- NEXT: 1 cycle, tile_done=1.
  - If pivot_x < MAP_W-BLK: pivot_x += STRIDE.
  - Else: pivot_x=0 and pivot_y += STRIDE.
  - If pivot_x == MAP_W-BLK and pivot_y == MAP_H-BLK -> DONE, pivots unchanged.
- Tile order: raster, x fastest. Tile count = ((MAP_W-BLK)/STRIDE+1) * ((MAP_H-BLK)/STRIDE+1).
- DONE: finish=1 held until start; busy=0.
- Minimum latency per tile with out_ready=1: (N+1) + N + N + 1 cycles = 3N+2.
- Reset asserted mid-operation: immediate return to IDLE. The partial tile is discarded and no tile_done is emitted.

Optional Feature:
SASA_CLAMP_EN:
- Defined: adds input port clamp_val [DW-1:0], sampled every SUB cycle. out_data = min(tile_max - buf[j], clamp_val).
- Undefined: the port does not exist and out_data is unclamped.
- Handshake and timing are identical in both cases.

Test Plan:
1. MAP_W=MAP_H=8, BLK=4, STRIDE=4, memory value = 16*y+x, out_ready=1.
   - Expect 4 tiles with pivots (0,0),(4,0),(0,4),(4,4).
   - Tile 0: tile_max=51; out_data sequence 51,50,49,48,35,...,0.
   - Exactly 4 tile_done pulses, then finish=1.
2. Tile of all-equal values 0x7F -> tile_max=0x7F, all 16 out_data = 0. Then a tile holding one 0xFF -> tile_max=0xFF (unsigned max at DW width).
3. out_ready toggled 1,0,0,1 pattern in SUB -> out_data stable while stalled, no element lost or duplicated, out_last on the 16th accepted beat only.
4. Reset pulsed during the SUB of tile 1 -> next cycle IDLE, all outputs 0. A new start restarts at pivot (0,0).
5. start pulsed during LOAD -> ignored (tile count unchanged). start in DONE -> finish drops, a new pass is produced identical to scenario 1.
6. SASA_CLAMP_EN defined, clamp_val=10, scenario 1 data -> tile 0 outputs saturate at 10 (first 10 outputs equal 10).
